pam4_rx_slicer_ber: RTL and testbench
=====================================

Name: pam4_rx_slicer_ber

Overview:
- Receive-side stage directly downstream of the noise-injection stage.
- Takes each noisy signed 8-bit sample with its valid. Slices it to a PAM4 symbol against three thresholds and outputs the decided symbol.
- Aligns each decision with the transmitted reference symbol through an internal FIFO. Accumulates symbol-error and bit-error counts over a programmable measurement window for BER reporting.

Parameters:
- DEPTH, 16, reference FIFO depth in entries (power of 2, ≥2)
- TH_HI, 8'sd64, upper threshold (signed)
- TH_LO, -8'sd64, lower threshold (signed); middle threshold fixed at 0
- CNT_W, 32, width of all statistics counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- sample_in  in  8  signed noisy sample
- sample_in_valid  in  1  sample qualifier
- ref_sym_in  in  2  transmitted symbol, Gray coded
- ref_sym_valid  in  1  reference qualifier
- start  in  1  pulse: clear counters, begin window
- window_len  in  CNT_W  symbols per window; sampled on start
- rx_sym  out  2  decided symbol, Gray coded
- rx_sym_valid  out  1  decision qualifier
- sym_count  out  CNT_W  symbols compared in current window
- sym_err_count  out  CNT_W  symbol mismatches
- bit_err_count  out  CNT_W  bit mismatches
- busy  out  1  window running
- done  out  1  window complete (level)
- ovf  out  1  sticky: reference pushed while FIFO full
- unf  out  1  sticky: sample arrived while FIFO empty

Behaviour:
- Reset: single clock domain; rst is synchronous and active-high. On rst, all outputs are 0, FIFO is empty and the FSM is in IDLE. rst mid-window aborts the window without completing it.
- Slicing (registered, 1-cycle latency):
  - sample ≥ TH_HI -> 2'b10 (+3)
  - 0 ≤ sample < TH_HI -> 2'b11 (+1)
  - TH_LO ≤ sample < 0 -> 2'b01 (-1)
  - sample < TH_LO -> 2'b00 (-3)
  - Comparisons are signed. A sample equal to a threshold takes the upper symbol.
- rx_sym_valid is asserted the cycle after sample_in_valid. rx_sym holds its value when not valid.
- FIFO:
  - Push on ref_sym_valid; pop on sample_in_valid.
  - Simultaneous push and pop while full: allowed, occupancy unchanged, no ovf.
  - Simultaneous push and pop while empty: the pushed entry is not bypassed. unf sets and the sample is not compared.
  - Push while full and no pop: entry dropped, ovf sets.
  - Pointers wrap modulo DEPTH.
- Compare (same cycle rx_sym is registered): the popped reference is compared to the decision.
  - sym_err increments by 1 if they differ.
  - bit_err increments by popcount(ref XOR rx), i.e. 0..2.
  - Counters update only in RUN. All counters saturate at 2^CNT_W-1.
- FSM:
  - IDLE: start -> RUN. Counters clear, window_len is latched, busy=1, done=0.
  - RUN: each compared symbol increments sym_count. When sym_count reaches the latched length, go to DONE on that same update (the final symbol is counted): busy=0, done=1.
  - RUN + start: restart. Counters clear, stay in RUN.
  - DONE: counters frozen. start -> RUN as from IDLE.
  - window_len=0: start goes directly to DONE with zero counts.
- FIFO and slicing operate in all states; only statistics are gated.
- ovf and unf clear only on rst or start.

Decomposition:
- Shared package (pam4_pkg):
  - PAM4 Gray symbol constants SYM_M3=2'b00, SYM_M1=2'b01, SYM_P1=2'b11, SYM_P3=2'b10
  - FSM state enum {IDLE, RUN, DONE}
  - Default threshold constants
- Sub-module: sym_ref_fifo, a synchronous FIFO with full, empty, ovf and unf outputs, instantiated once.
- Slicer, comparator and FSM stay in the top module.

Test Plan:
- Slicer boundaries: sample sequence 127, 64, 63, 0, -1, -64, -65, -128, one per cycle (8 samples) -> rx_sym 10,10,11,11,01,01,00,00, each one cycle later.
- Clean window: start with window_len=100; reference stream pushed one cycle ahead of matching samples -> after 100 symbols sym_count=100, sym_err=0, bit_err=0, done=1, busy=0.
- Injected errors: ref +3 (10) vs sample -100 (00) five times in a 20-symbol window -> sym_err=5, bit_err=5. Ref +1 (11) vs sample -100 (00) three times -> bit_err increases by 6.
- FIFO boundaries: DEPTH+1 pushes with no samples -> ovf=1, exactly DEPTH entries are compared afterwards. Sample with FIFO empty -> unf=1 and sym_count unchanged.
- Control corners: start during RUN at sym_count=40 -> counters 0 next cycle, window restarts. window_len=0 -> done one cycle after start. rst mid-window -> all outputs 0 and state IDLE.

Source files
------------

// File: rtl/pam4_pkg.sv
// Shared PAM4 definitions: Gray symbol codes, window FSM states, default
// slicer thresholds and a 2-bit popcount used for bit-error accounting.
package pam4_pkg;

  localparam logic [1:0] SYM_M3 = 2'b00;
  localparam logic [1:0] SYM_M1 = 2'b01;
  localparam logic [1:0] SYM_P1 = 2'b11;
  localparam logic [1:0] SYM_P3 = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic signed [7:0] TH_HI_DEF = 8'sd64;
  localparam logic signed [7:0] TH_LO_DEF = -8'sd64;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[1]} + {1'b0, v[0]};
  endfunction

endpackage

// File: rtl/sym_ref_fifo.sv
// Reference-symbol FIFO: holds transmitted symbols until the matching noisy
// sample arrives. Sticky ovf/unf flags clear on rst or clr.
module sym_ref_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic         ovf,
  output logic         unf
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          ovf_r;
  logic          unf_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full  = (count_r == (AW+1)'(DEPTH));
  assign empty = (count_r == {(AW+1){1'b0}});
  assign head  = mem_r[rd_ptr_r];
  assign ovf   = ovf_r;
  assign unf   = unf_r;

  // A push into a full FIFO is only accepted when a pop frees a slot this cycle.
  always_comb begin
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
      if (clr) begin
        ovf_r <= 1'b0;
        unf_r <= 1'b0;
      end else begin
        if (push && full && !pop) begin
          ovf_r <= 1'b1;
        end
        if (pop && empty) begin
          unf_r <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pam4_rx_slicer_ber.sv
// PAM4 receive slicer with reference alignment and windowed symbol/bit error
// counting for BER measurement.
module pam4_rx_slicer_ber
  import pam4_pkg::*;
#(
  parameter int               DEPTH = 16,
  parameter logic signed [7:0] TH_HI = TH_HI_DEF,
  parameter logic signed [7:0] TH_LO = TH_LO_DEF,
  parameter int               CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [7:0]   sample_in,
  input  logic                sample_in_valid,
  input  logic [1:0]          ref_sym_in,
  input  logic                ref_sym_valid,
  input  logic                start,
  input  logic [CNT_W-1:0]    window_len,
  output logic [1:0]          rx_sym,
  output logic                rx_sym_valid,
  output logic [CNT_W-1:0]    sym_count,
  output logic [CNT_W-1:0]    sym_err_count,
  output logic [CNT_W-1:0]    bit_err_count,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic                unf
);

  state_e           state_r;
  logic [CNT_W-1:0] len_r;
  logic [CNT_W-1:0] sym_count_r;
  logic [CNT_W-1:0] sym_err_r;
  logic [CNT_W-1:0] bit_err_r;
  logic             busy_r;
  logic             done_r;
  logic [1:0]       rx_sym_r;
  logic             rx_sym_valid_r;

  logic [1:0]       slice_s;
  logic [1:0]       ref_head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             cmp_s;
  logic [1:0]       diff_s;
  logic [CNT_W:0]   sym_inc_s;
  logic [CNT_W:0]   serr_inc_s;
  logic [CNT_W:0]   berr_inc_s;
  logic [CNT_W-1:0] sym_next_s;
  logic [CNT_W-1:0] serr_next_s;
  logic [CNT_W-1:0] berr_next_s;

  sym_ref_fifo #(
    .DEPTH (DEPTH),
    .W     (2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (start),
    .push      (ref_sym_valid),
    .push_data (ref_sym_in),
    .pop       (sample_in_valid),
    .head      (ref_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .ovf       (ovf),
    .unf       (unf)
  );

  // Three-threshold signed slicer; a sample on a threshold takes the upper symbol.
  always_comb begin
    if (sample_in >= TH_HI) begin
      slice_s = SYM_P3;
    end else if (sample_in >= 8'sd0) begin
      slice_s = SYM_P1;
    end else if (sample_in >= TH_LO) begin
      slice_s = SYM_M1;
    end else begin
      slice_s = SYM_M3;
    end
  end

  // Compare the current decision against the aligned reference; saturating sums.
  always_comb begin
    cmp_s       = sample_in_valid & ~fifo_empty_s;
    diff_s      = ref_head_s ^ slice_s;
    sym_inc_s   = {1'b0, sym_count_r} + (CNT_W+1)'(1);
    serr_inc_s  = {1'b0, sym_err_r} + {{CNT_W{1'b0}}, |diff_s};
    berr_inc_s  = {1'b0, bit_err_r} + {{(CNT_W-1){1'b0}}, popcount2(diff_s)};
    sym_next_s  = sym_inc_s[CNT_W]  ? {CNT_W{1'b1}} : sym_inc_s[CNT_W-1:0];
    serr_next_s = serr_inc_s[CNT_W] ? {CNT_W{1'b1}} : serr_inc_s[CNT_W-1:0];
    berr_next_s = berr_inc_s[CNT_W] ? {CNT_W{1'b1}} : berr_inc_s[CNT_W-1:0];
  end

  // Registered decision output; holds the last symbol between valid samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sym_r       <= 2'b00;
      rx_sym_valid_r <= 1'b0;
    end else begin
      rx_sym_valid_r <= sample_in_valid;
      if (sample_in_valid) begin
        rx_sym_r <= slice_s;
      end else begin
        rx_sym_r <= rx_sym_r;
      end
    end
  end

  // Measurement-window FSM and statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      len_r       <= {CNT_W{1'b0}};
      sym_count_r <= {CNT_W{1'b0}};
      sym_err_r   <= {CNT_W{1'b0}};
      bit_err_r   <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else if (start) begin
      len_r       <= window_len;
      sym_count_r <= {CNT_W{1'b0}};
      sym_err_r   <= {CNT_W{1'b0}};
      bit_err_r   <= {CNT_W{1'b0}};
      if (window_len == {CNT_W{1'b0}}) begin
        state_r <= DONE;
        busy_r  <= 1'b0;
        done_r  <= 1'b1;
      end else begin
        state_r <= RUN;
        busy_r  <= 1'b1;
        done_r  <= 1'b0;
      end
    end else begin
      case (state_r)
        RUN: begin
          if (cmp_s) begin
            sym_count_r <= sym_next_s;
            sym_err_r   <= serr_next_s;
            bit_err_r   <= berr_next_s;
            if (sym_next_s == len_r) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= RUN;
            end
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= state_r;
        end
      endcase
    end
  end

  assign rx_sym        = rx_sym_r;
  assign rx_sym_valid  = rx_sym_valid_r;
  assign sym_count     = sym_count_r;
  assign sym_err_count = sym_err_r;
  assign bit_err_count = bit_err_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule

// File: tb/tb_pam4_rx_slicer_ber.sv
// Directed self-checking bench for pam4_rx_slicer_ber: slicer boundaries,
// clean and errored windows, FIFO over/underflow and window control corners.
module tb_pam4_rx_slicer_ber;
  import pam4_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] sample_in;
  logic              sample_in_valid;
  logic [1:0]        ref_sym_in;
  logic              ref_sym_valid;
  logic              start;
  logic [31:0]       window_len;
  logic [1:0]        rx_sym;
  logic              rx_sym_valid;
  logic [31:0]       sym_count;
  logic [31:0]       sym_err_count;
  logic [31:0]       bit_err_count;
  logic              busy;
  logic              done;
  logic              ovf;
  logic              unf;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0]        sym_tbl [4] = '{SYM_M3, SYM_M1, SYM_P1, SYM_P3};
  logic signed [7:0] smp_tbl [4] = '{-8'sd100, -8'sd30, 8'sd30, 8'sd100};
  logic signed [7:0] bnd_smp [8] = '{8'sd127, 8'sd64, 8'sd63, 8'sd0,
                                     -8'sd1, -8'sd64, -8'sd65, -8'sd128};
  logic [1:0]        bnd_exp [8] = '{2'b10, 2'b10, 2'b11, 2'b11,
                                     2'b01, 2'b01, 2'b00, 2'b00};

  pam4_rx_slicer_ber dut (
    .clk             (clk),
    .rst             (rst),
    .sample_in       (sample_in),
    .sample_in_valid (sample_in_valid),
    .ref_sym_in      (ref_sym_in),
    .ref_sym_valid   (ref_sym_valid),
    .start           (start),
    .window_len      (window_len),
    .rx_sym          (rx_sym),
    .rx_sym_valid    (rx_sym_valid),
    .sym_count       (sym_count),
    .sym_err_count   (sym_err_count),
    .bit_err_count   (bit_err_count),
    .busy            (busy),
    .done            (done),
    .ovf             (ovf),
    .unf             (unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] len);
    start      = 1'b1;
    window_len = len;
    cyc();
    start = 1'b0;
  endtask

  // Push the reference one cycle ahead of its sample.
  task automatic one_sym(input logic [1:0] r, input logic signed [7:0] s);
    ref_sym_in    = r;
    ref_sym_valid = 1'b1;
    cyc();
    ref_sym_valid   = 1'b0;
    sample_in       = s;
    sample_in_valid = 1'b1;
    cyc();
    sample_in_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_sym"}, 32'(rx_sym), 32'd0);
    check({tag, "_rx_valid"}, 32'(rx_sym_valid), 32'd0);
    check({tag, "_sym_count"}, sym_count, 32'd0);
    check({tag, "_sym_err"}, sym_err_count, 32'd0);
    check({tag, "_bit_err"}, bit_err_count, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
    check({tag, "_unf"}, 32'(unf), 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    sample_in       = 8'sd0;
    sample_in_valid = 1'b0;
    ref_sym_in      = 2'b00;
    ref_sym_valid   = 1'b0;
    start           = 1'b0;
    window_len      = 32'd0;
    cyc();
    cyc();
    check_all_zero("reset");
    rst = 1'b0;

    // Slicer boundaries, one sample per cycle; FIFO empty so unf sets.
    for (int i = 0; i < 8; i++) begin
      sample_in       = bnd_smp[i];
      sample_in_valid = 1'b1;
      cyc();
      check($sformatf("slice_%0d", i), 32'(rx_sym), 32'(bnd_exp[i]));
      check($sformatf("slice_valid_%0d", i), 32'(rx_sym_valid), 32'd1);
    end
    sample_in_valid = 1'b0;
    sample_in       = 8'sd127;
    cyc();
    check("slice_valid_low", 32'(rx_sym_valid), 32'd0);
    check("slice_hold", 32'(rx_sym), 32'(2'b00));
    check("idle_unf", 32'(unf), 32'd1);
    check("idle_no_count", sym_count, 32'd0);

    // Clean 100-symbol window.
    pulse_start(32'd100);
    check("clean_busy", 32'(busy), 32'd1);
    check("clean_done0", 32'(done), 32'd0);
    check("clean_unf_clr", 32'(unf), 32'd0);
    for (int k = 0; k < 99; k++) begin
      one_sym(sym_tbl[k % 4], smp_tbl[k % 4]);
    end
    check("clean_cnt99", sym_count, 32'd99);
    check("clean_busy99", 32'(busy), 32'd1);
    one_sym(sym_tbl[3], smp_tbl[3]);
    check("clean_cnt", sym_count, 32'd100);
    check("clean_serr", sym_err_count, 32'd0);
    check("clean_berr", bit_err_count, 32'd0);
    check("clean_done", 32'(done), 32'd1);
    check("clean_busy_end", 32'(busy), 32'd0);
    one_sym(sym_tbl[0], smp_tbl[3]);
    check("frozen_cnt", sym_count, 32'd100);
    check("frozen_serr", sym_err_count, 32'd0);

    // Injected errors in a 20-symbol window.
    pulse_start(32'd20);
    for (int k = 0; k < 5; k++) begin
      one_sym(SYM_P3, -8'sd100);
    end
    check("err_serr5", sym_err_count, 32'd5);
    check("err_berr5", bit_err_count, 32'd5);
    for (int k = 0; k < 3; k++) begin
      one_sym(SYM_P1, -8'sd100);
    end
    check("err_serr8", sym_err_count, 32'd8);
    check("err_berr11", bit_err_count, 32'd11);
    for (int k = 8; k < 20; k++) begin
      one_sym(sym_tbl[k % 4], smp_tbl[k % 4]);
    end
    check("err_cnt", sym_count, 32'd20);
    check("err_serr_end", sym_err_count, 32'd8);
    check("err_berr_end", bit_err_count, 32'd11);
    check("err_done", 32'(done), 32'd1);

    // FIFO overflow: DEPTH+1 pushes, the last one dropped.
    pulse_start(32'd50);
    for (int i = 0; i < 17; i++) begin
      ref_sym_in    = (i < 16) ? sym_tbl[i % 4] : sym_tbl[2];
      ref_sym_valid = 1'b1;
      cyc();
    end
    ref_sym_valid = 1'b0;
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_cnt0", sym_count, 32'd0);
    for (int i = 0; i < 16; i++) begin
      sample_in       = smp_tbl[i % 4];
      sample_in_valid = 1'b1;
      cyc();
    end
    sample_in_valid = 1'b0;
    check("ovf_cnt16", sym_count, 32'd16);
    check("ovf_serr0", sym_err_count, 32'd0);
    check("ovf_unf0", 32'(unf), 32'd0);
    sample_in       = 8'sd100;
    sample_in_valid = 1'b1;
    cyc();
    sample_in_valid = 1'b0;
    check("unf_set", 32'(unf), 32'd1);
    check("unf_cnt", sym_count, 32'd16);
    check("unf_busy", 32'(busy), 32'd1);

    // Restart during RUN at sym_count=40.
    pulse_start(32'd100);
    check("restart_ovf_clr", 32'(ovf), 32'd0);
    for (int k = 0; k < 40; k++) begin
      one_sym(sym_tbl[k % 4], smp_tbl[k % 4]);
    end
    check("restart_cnt40", sym_count, 32'd40);
    pulse_start(32'd100);
    check("restart_cnt0", sym_count, 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    for (int k = 0; k < 3; k++) begin
      one_sym(sym_tbl[k % 4], smp_tbl[k % 4]);
    end
    check("restart_cnt3", sym_count, 32'd3);

    // Zero-length window completes immediately.
    pulse_start(32'd0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_cnt", sym_count, 32'd0);

    // Reset mid-window, with one reference left in the FIFO.
    pulse_start(32'd100);
    for (int k = 0; k < 5; k++) begin
      one_sym(SYM_P3, -8'sd100);
    end
    ref_sym_in    = SYM_P3;
    ref_sym_valid = 1'b1;
    cyc();
    ref_sym_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_all_zero("midrst");
    sample_in       = 8'sd100;
    sample_in_valid = 1'b1;
    cyc();
    sample_in_valid = 1'b0;
    check("midrst_fifo_empty", 32'(unf), 32'd1);
    check("midrst_idle_cnt", sym_count, 32'd0);
    check("midrst_idle_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
